demux4_stream: RTL and testbench
================================

DEMUX4_STREAM -- requirements
Module: demux4_stream

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, which sets the data width of the input word and of each output channel.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port in_data, input, WIDTH bits: the word offered for routing.
REQ-005 The module SHALL have port in_sel, input, 2 bits: the destination channel (0..3), qualified by in_valid.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the upstream word is offered.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the module accepts the offered word this cycle.
REQ-008 The module SHALL have port out_data, output, 4*WIDTH bits: channel n occupies bits [n*WIDTH +: WIDTH].
REQ-009 The module SHALL have port out_valid, output, 4 bits: per-channel holding register full.
REQ-010 The module SHALL have port out_ready, input, 4 bits: per-channel downstream accept.
REQ-011 The module SHALL have port proto_err, output, 1 bit: sticky upstream-protocol-violation flag.
REQ-012 The module SHALL have port acc_cnt, output, 32 bits: per-channel accept counters, channel n at bits [8n+7:8n].

Function
REQ-013 Each channel SHALL hold a one-entry register (data plus valid flag).
REQ-014 in_ready SHALL equal ~out_valid[in_sel] | out_ready[in_sel], combinationally, and SHALL be independent of in_valid.
REQ-015 An accept (in_valid & in_ready at a clock edge) SHALL load in_data into channel in_sel and set out_valid[in_sel] at that edge; latency input-to-output is 1 cycle.
REQ-016 A drain on channel n (out_valid[n] & out_ready[n]) SHALL clear out_valid[n] unless the same edge loads channel n, in which case out_valid[n] stays 1 and out_data holds the new word.
REQ-017 Channels SHALL be independent: a stalled channel SHALL NOT block accepts to other channels.
REQ-018 out_data[n] SHALL be stable while out_valid[n]=1 and out_ready[n]=0.
REQ-019 The out_data bits of an empty channel SHALL retain the last loaded word (the value is don't-care for downstream).
REQ-020 proto_err SHALL set when, in the cycle after in_valid=1 & in_ready=0, in_valid drops or in_data/in_sel change; once set it SHALL stay set until reset.
REQ-021 At most one word SHALL be accepted per cycle; there SHALL be no broadcast.

Reset
REQ-022 rst=1 SHALL asynchronously clear out_valid to 4'b0000, out_data to all zeros, proto_err to 0 and acc_cnt to 0.
REQ-023 A word held in a channel when reset asserts SHALL be discarded; no accept or drain SHALL occur while rst=1.
REQ-024 While rst=1 and for the first edge after release, in_ready SHALL be 1 as a consequence of the empty channels.

Configuration
REQ-025 The macro DEMUX4_STREAM_ACC_CNT_EN SHALL control the accept counters.
REQ-026 With DEMUX4_STREAM_ACC_CNT_EN defined, each channel SHALL have an 8-bit counter that increments on every accept to that channel and saturates at 255.
REQ-027 With DEMUX4_STREAM_ACC_CNT_EN not defined, acc_cnt SHALL be a constant 0 and no counter logic SHALL be present.

Verification
REQ-028 The bench SHALL cover reset: after reset, out_valid=0000, out_data=0, proto_err=0, in_ready=1 for every in_sel.
REQ-029 The bench SHALL cover a single route: in_data=8'hA5, in_sel=2, valid for one cycle, out_ready=0000 -> next cycle out_valid=0100, out_data[23:16]=A5, and in_ready=0 when in_sel=2.
REQ-030 The bench SHALL cover simultaneous drain and load: channel 1 holds 8'h11, out_ready[1]=1, accept 8'h22 to channel 1 in the same cycle -> out_valid[1] stays 1, out_data[15:8]=22, and the 11 word is consumed exactly once.
REQ-031 The bench SHALL cover independence: channel 0 is full and stalled, and words 8'h30 and 8'h31 are sent to channel 3 -> both are accepted in back-to-back cycles with out_ready[3]=1, while channel 0 is unchanged.
REQ-032 The bench SHALL cover a protocol violation: hold in_valid=1 to a stalled channel, then change in_data -> proto_err=1 from the next cycle, still 1 after 10 cycles, and cleared by rst.
REQ-033 The bench SHALL cover the counters: with DEMUX4_STREAM_ACC_CNT_EN defined, 300 accepts to channel 0 -> acc_cnt[7:0]=255 and other fields 0; with the macro undefined, acc_cnt=0.

Source files
------------

// File: rtl/demux4_stream.sv
// One-in, four-out stream demultiplexer: each channel owns a one-entry holding register.
// Optional per-channel saturating accept counters are enabled by defining DEMUX4_STREAM_ACC_CNT_EN.
module demux4_stream #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic               proto_err,
  output logic [31:0]        acc_cnt
);

  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic [3:0]       load;
  logic [3:0]       drain;
  logic             accept;

  logic             stall_q;
  logic [WIDTH-1:0] stall_data_q;
  logic [1:0]       stall_sel_q;
  logic             err_q;
  logic             violation;

  // A full channel still accepts when its downstream drains in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load     = '0;
    drain    = valid_q & out_ready;
    in_ready = ~valid_q[in_sel] | out_ready[in_sel];
    accept   = in_valid & in_ready;
    if (accept) begin
      load[in_sel] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the data registers are reset too, because an idle channel must present zeros after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int n = 0; n < 4; n++) begin
        data_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (load[n]) begin
          data_q[n]  <= in_data;
          valid_q[n] <= 1'b1;
        end else if (drain[n]) begin
          valid_q[n] <= 1'b0;
        end
      end
    end
  end

  // An offered-but-refused word must be re-offered unchanged on the next cycle.
  assign violation = stall_q & (~in_valid | (in_data != stall_data_q) | (in_sel != stall_sel_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q      <= 1'b0;
      stall_data_q <= '0;
      stall_sel_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      stall_q      <= in_valid & ~in_ready;
      stall_data_q <= in_data;
      stall_sel_q  <= in_sel;
      if (violation) begin
        err_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign out_valid = valid_q;
  assign proto_err = err_q;

`ifdef DEMUX4_STREAM_ACC_CNT_EN
  logic [7:0] cnt_q [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (load[n] && (cnt_q[n] != 8'hFF)) begin
          cnt_q[n] <= cnt_q[n] + 8'd1;
        end
      end
    end
  end

  assign acc_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  assign acc_cnt = '0;
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed vectors plus a per-cycle compare
// against an array-based channel model.
module tb_demux4_stream;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic             proto_err;
  logic [31:0]      acc_cnt;

  demux4_stream #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .proto_err (proto_err),
    .acc_cnt   (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one slot per channel, plus the last refused offer.
  logic       m_valid [4];
  logic [7:0] m_data  [4];
  int         m_cnt   [4];
  logic       m_err;
  logic       m_stall;
  logic [7:0] m_sdata;
  logic [1:0] m_ssel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        m_valid[n] = 1'b0;
        m_data[n]  = 8'h00;
        m_cnt[n]   = 0;
      end
      m_err   = 1'b0;
      m_stall = 1'b0;
      m_sdata = 8'h00;
      m_ssel  = 2'd0;
    end else begin
      logic acc;
      acc = in_valid && (!m_valid[in_sel] || out_ready[in_sel]);
      if (m_stall && (!in_valid || in_data != m_sdata || in_sel != m_ssel)) m_err = 1'b1;
      m_stall = in_valid && !acc;
      m_sdata = in_data;
      m_ssel  = in_sel;
      for (int n = 0; n < 4; n++) begin
        if (m_valid[n] && out_ready[n]) m_valid[n] = 1'b0;
      end
      if (acc) begin
        m_valid[in_sel] = 1'b1;
        m_data[in_sel]  = in_data;
`ifdef DEMUX4_STREAM_ACC_CNT_EN
        if (m_cnt[in_sel] < 255) m_cnt[in_sel] = m_cnt[in_sel] + 1;
`endif
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [31:0] ec;
    for (int n = 0; n < 4; n++) begin
      ev[n]           = m_valid[n];
      ed[n*8 +: 8]    = m_data[n];
      ec[n*8 +: 8]    = m_cnt[n][7:0];
    end
    check("cmp_out_valid", {60'd0, out_valid}, {60'd0, ev});
    check("cmp_out_data",  {32'd0, out_data},  {32'd0, ed});
    check("cmp_proto_err", {63'd0, proto_err}, {63'd0, m_err});
    check("cmp_acc_cnt",   {32'd0, acc_cnt},   {32'd0, ec});
    check("cmp_in_ready",  {63'd0, in_ready},
          {63'd0, (!m_valid[in_sel] || out_ready[in_sel])});
  end

  // Counts how often the 8'h11 word on channel 1 is handed downstream.
  int drains_11 = 0;
  always @(posedge clk) begin
    if (!rst && out_valid[1] && out_ready[1] && out_data[15:8] == 8'h11) drains_11++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    rst       = 1'b0;
    #1 rst    = 1'b1;

    // Reset state
    settle();
    check("rst_out_valid", {60'd0, out_valid}, 64'h0);
    check("rst_out_data",  {32'd0, out_data},  64'h0);
    check("rst_proto_err", {63'd0, proto_err}, 64'h0);
    check("rst_acc_cnt",   {32'd0, acc_cnt},   64'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = s[1:0];
      #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'h1);
    end
    in_sel = 2'd0;
    step();
    rst = 1'b0;

    // Single route to channel 2
    in_data = 8'hA5; in_sel = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    settle();
    check("route_out_valid", {60'd0, out_valid}, 64'h4);
    check("route_data2",     {56'd0, out_data[23:16]}, 64'hA5);
    check("route_in_ready",  {63'd0, in_ready}, 64'h0);
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;

    // Simultaneous drain and load on channel 1
    in_data = 8'h11; in_sel = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    settle();
    check("dl_hold11", {56'd0, out_data[15:8]}, 64'h11);
    out_ready = 4'b0010;
    in_data = 8'h22; in_valid = 1'b1;
    settle();
    check("dl_in_ready", {63'd0, in_ready}, 64'h1);
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    settle();
    check("dl_valid1",  {63'd0, out_valid[1]}, 64'h1);
    check("dl_data22",  {56'd0, out_data[15:8]}, 64'h22);
    check("dl_once_11", 64'(drains_11), 64'd1);
    out_ready = 4'b0010;
    step();
    out_ready = 4'b0000;

    // Independence: channel 0 stalled, channel 3 streams
    in_data = 8'h55; in_sel = 2'd0; in_valid = 1'b1;
    step();
    out_ready = 4'b1000;
    in_data = 8'h30; in_sel = 2'd3;
    settle();
    check("ind_ready30", {63'd0, in_ready}, 64'h1);
    step();
    in_data = 8'h31;
    settle();
    check("ind_ready31", {63'd0, in_ready}, 64'h1);
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    settle();
    check("ind_valid",  {60'd0, out_valid}, 64'h9);
    check("ind_data3",  {56'd0, out_data[31:24]}, 64'h31);
    check("ind_data0",  {56'd0, out_data[7:0]},   64'h55);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;

    // Protocol violation on a stalled channel
    in_data = 8'h77; in_sel = 2'd2; in_valid = 1'b1;
    step();
    in_data = 8'h88;
    step();
    in_data = 8'h89;
    settle();
    check("pe_before", {63'd0, proto_err}, 64'h0);
    step();
    in_valid = 1'b0;
    settle();
    check("pe_set", {63'd0, proto_err}, 64'h1);
    repeat (10) step();
    settle();
    check("pe_sticky", {63'd0, proto_err}, 64'h1);
    rst = 1'b1;
    #1;
    check("pe_cleared",  {63'd0, proto_err}, 64'h0);
    check("rst2_valid",  {60'd0, out_valid}, 64'h0);
    step();
    rst = 1'b0;

    // Accept counters: 300 accepts to channel 0
    in_sel = 2'd0; out_ready = 4'b0001; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = i[7:0];
      step();
    end
    in_valid = 1'b0; out_ready = 4'b0000;
    settle();
    check("cnt_last_data", {56'd0, out_data[7:0]}, 64'h2B);
`ifdef DEMUX4_STREAM_ACC_CNT_EN
    check("cnt_acc", {32'd0, acc_cnt}, 64'h0000_00FF);
`else
    check("cnt_acc", {32'd0, acc_cnt}, 64'h0);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
